// File: rtl/apb_xfer_pkg.sv
// apb_xfer_pkg: shared types and constants for the APB transfer arbiter.
// Encodings, bus widths and the scheduler state enum.
package apb_xfer_pkg;

    localparam logic [1:0] ENC_WR = 2'b01;
    localparam logic [1:0] ENC_RD = 2'b10;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RD,
        ST_WAIT_WR,
        ST_RESP
    } xfer_state_t;

    function automatic logic enc_legal(input logic [1:0] enc);
        return (enc == ENC_WR) || (enc == ENC_RD);
    endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// apb_rr_pick: combinational round-robin picker.
// Searches upward from ptr_i and returns a one-hot grant plus its index.
module apb_rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    logic found;
    int   j;

    // First requester at or above the pointer, wrapping past NREQ-1
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr_i) + i;
            if (j >= NREQ) j = j - NREQ;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && (k == j) && req_valid_i[k]) begin
                    found      = 1'b1;
                    grant_o[k] = 1'b1;
                    idx_o      = PW'(k);
                end
            end
        end
    end

    assign any_o = |req_valid_i;

endmodule

// File: rtl/apb_xfer_arbiter.sv
// apb_xfer_arbiter: round-robin scheduler in front of apb_top's trf port.
// One command in flight; reads end on a strobe, writes after WR_LAT cycles.
module apb_xfer_arbiter
    import apb_xfer_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int WR_LAT  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                   pclk,
    input  logic                   prstn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [2*NREQ-1:0]      req_enc,
    input  logic [ADDR_W*NREQ-1:0] req_addr,
    input  logic [DATA_W*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   trf_valid,
    output logic [1:0]             trf_enc,
    output logic [ADDR_W-1:0]      trf_addr,
    output logic [DATA_W-1:0]      trf_wdata,
    input  logic [DATA_W-1:0]      trf_rdata,
    input  logic                   trf_rdata_valid
);

    localparam int PW = $clog2(NREQ);
    localparam logic [7:0] WR_LAST = 8'(WR_LAT - 1);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    xfer_state_t         state_q;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [NREQ-1:0]     owner_q;
    logic [7:0]          cnt_q;
    logic [NREQ-1:0]     req_ready_q, rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                trf_valid_q;
    logic [1:0]          trf_enc_q;
    logic [ADDR_W-1:0]   trf_addr_q;
    logic [DATA_W-1:0]   trf_wdata_q;

    logic [NREQ-1:0]     grant;
    logic [PW-1:0]       pick_idx;
    logic                pick_any;
    logic [1:0]          sel_enc;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    apb_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req_valid_i (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .idx_o       (pick_idx),
        .any_o       (pick_any)
    );

    // Route the winner's command fields and compute the next pointer
    always_comb begin
        sel_enc   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_enc   = req_enc[2*i +: 2];
                sel_addr  = req_addr[ADDR_W*i +: ADDR_W];
                sel_wdata = req_wdata[DATA_W*i +: DATA_W];
            end
        end
        ptr_d = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    end

    // Scheduler FSM with registered outputs; counters stop at their limit
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            trf_valid_q <= 1'b0;
            trf_enc_q   <= 2'b00;
            trf_addr_q  <= '0;
            trf_wdata_q <= '0;
        end else begin
            trf_valid_q <= 1'b0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        owner_q <= grant;
                        ptr_q   <= ptr_d;
                        cnt_q   <= '0;
                        if (enc_legal(sel_enc)) begin
                            trf_valid_q <= 1'b1;
                            trf_enc_q   <= sel_enc;
                            trf_addr_q  <= sel_addr;
                            trf_wdata_q <= sel_wdata;
                            req_ready_q <= grant;
                            state_q     <= ST_ISSUE;
                        end else begin
                            rsp_valid_q <= grant;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                            state_q     <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= (trf_enc_q == ENC_RD) ? ST_WAIT_RD : ST_WAIT_WR;
                end
                ST_WAIT_RD: begin
                    if (trf_rdata_valid) begin
                        rsp_valid_q <= owner_q;
                        rsp_rdata_q <= trf_rdata;
                        rsp_err_q   <= 1'b0;
                        state_q     <= ST_RESP;
                    end else if (cnt_q >= TO_LAST) begin
                        rsp_valid_q <= owner_q;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_WAIT_WR: begin
                    if (cnt_q >= WR_LAST) begin
                        rsp_valid_q <= owner_q;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_RESP: begin
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != ST_IDLE);
    assign trf_valid = trf_valid_q;
    assign trf_enc   = trf_enc_q;
    assign trf_addr  = trf_addr_q;
    assign trf_wdata = trf_wdata_q;

endmodule

// File: tb/tb_apb_xfer_arbiter.sv
// tb_apb_xfer_arbiter: directed bench for apb_xfer_arbiter.
// NREQ=2, WR_LAT=2, TIMEOUT=16; inputs driven and outputs sampled on negedge.
module tb_apb_xfer_arbiter;

    localparam int NREQ    = 2;
    localparam int WR_LAT  = 2;
    localparam int TIMEOUT = 16;

    logic        pclk = 1'b0;
    logic        prstn = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [3:0]  req_enc = '0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        trf_valid;
    logic [1:0]  trf_enc;
    logic [7:0]  trf_addr;
    logic [7:0]  trf_wdata;
    logic [7:0]  trf_rdata = '0;
    logic        trf_rdata_valid = 1'b0;

    int          n_chk = 0;
    int          n_pass = 0;
    int          ng;
    int          n;
    logic [1:0]  gr [4];
    logic [7:0]  ga [4];
    int          gc [4];
    logic [1:0]  seen;

    apb_xfer_arbiter #(
        .NREQ(NREQ), .WR_LAT(WR_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk            (pclk),
        .prstn           (prstn),
        .req_valid       (req_valid),
        .req_enc         (req_enc),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .busy            (busy),
        .trf_valid       (trf_valid),
        .trf_enc         (trf_enc),
        .trf_addr        (trf_addr),
        .trf_wdata       (trf_wdata),
        .trf_rdata       (trf_rdata),
        .trf_rdata_valid (trf_rdata_valid)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(negedge pclk);
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < 40) begin
            tick();
            c++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        check("rst_out_a", {req_ready, rsp_valid, rsp_rdata, rsp_err, busy},
              32'd0);
        check("rst_out_b", {trf_valid, trf_enc, trf_addr, trf_wdata}, 32'd0);
        prstn = 1'b1;
        tick();

        // single write from req 0
        req_enc   = 4'b0001;
        req_addr  = 16'h0001;
        req_wdata = 16'h0002;
        req_valid = 2'b01;
        tick();
        check("wr_tvalid", 32'(trf_valid), 32'd1);
        check("wr_cmd", {trf_enc, trf_addr, trf_wdata}, {2'b01, 8'h01, 8'h02});
        check("wr_ready", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        tick();
        check("wr_pulse", {trf_valid, req_ready}, 32'd0);
        tick();
        check("wr_early", 32'(rsp_valid), 32'd0);
        tick();
        check("wr_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b01, 1'b0, 8'h00});
        tick();
        check("wr_idle", {busy, rsp_valid}, 32'd0);

        // read from req 1, strobe three cycles after issue
        req_enc   = 4'b1000;
        req_addr  = 16'h0400;
        req_valid = 2'b10;
        tick();
        check("rd_tvalid", 32'(trf_valid), 32'd1);
        check("rd_cmd", {trf_enc, trf_addr}, {2'b10, 8'h04});
        check("rd_ready", 32'(req_ready), 32'h2);
        req_valid = 2'b00;
        tick();
        check("rd_pulse", 32'(trf_valid), 32'd0);
        tick();
        tick();
        check("rd_early", 32'(rsp_valid), 32'd0);
        trf_rdata       = 8'h05;
        trf_rdata_valid = 1'b1;
        tick();
        trf_rdata_valid = 1'b0;
        trf_rdata       = 8'h00;
        check("rd_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 1'b0, 8'h05});
        check("rd_hold", 32'(trf_addr), 32'h04);
        tick();
        check("rd_idle", 32'(busy), 32'd0);

        // stray strobe while idle must do nothing
        trf_rdata       = 8'hAA;
        trf_rdata_valid = 1'b1;
        tick();
        trf_rdata_valid = 1'b0;
        trf_rdata       = 8'h00;
        tick();
        check("stray", {busy, rsp_valid, trf_valid}, 32'd0);

        // contention: both requesters write continuously
        req_enc   = 4'b0101;
        req_addr  = 16'h1110;
        req_wdata = 16'h2120;
        req_valid = 2'b11;
        ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            tick();
            if (req_ready != 2'b00) begin
                gr[ng] = req_ready;
                ga[ng] = trf_addr;
                gc[ng] = c;
                ng++;
            end
        end
        req_valid = 2'b00;
        check("cont_cnt", 32'(ng), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < ng) begin
                check("cont_grant", 32'(gr[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
                check("cont_addr", 32'(ga[k]), (k % 2 == 0) ? 32'h10 : 32'h11);
            end
            if (k > 0 && k < ng)
                check("cont_gap", 32'(gc[k] - gc[k-1]), 32'(WR_LAT + 3));
        end
        wait_idle("cont_idle");

        // illegal encoding from req 0
        req_enc   = 4'b0011;
        req_valid = 2'b01;
        tick();
        check("ill_notrf", {trf_valid, req_ready}, 32'd0);
        check("ill_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b01, 1'b1, 8'h00});
        check("ill_hold", 32'(trf_enc), 32'h1);
        req_valid = 2'b00;
        tick();
        check("ill_idle", 32'(busy), 32'd0);

        // read timeout from req 1
        req_enc   = 4'b1000;
        req_addr  = 16'h2000;
        req_valid = 2'b10;
        tick();
        check("to_ready", 32'(req_ready), 32'h2);
        req_valid = 2'b00;
        n = 0;
        while (rsp_valid == 2'b00 && n < 40) begin
            tick();
            n++;
        end
        check("to_lat", 32'(n), 32'(TIMEOUT + 1));
        check("to_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 1'b1, 8'h00});
        tick();
        check("to_idle", 32'(busy), 32'd0);

        // strobe on the last WAIT_RD cycle counts as success
        req_enc   = 4'b0010;
        req_addr  = 16'h0030;
        req_valid = 2'b01;
        tick();
        check("bd_ready", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        repeat (TIMEOUT - 1) tick();
        check("bd_early", 32'(rsp_valid), 32'd0);
        tick();
        trf_rdata       = 8'h5A;
        trf_rdata_valid = 1'b1;
        tick();
        trf_rdata_valid = 1'b0;
        trf_rdata       = 8'h00;
        check("bd_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b01, 1'b0, 8'h5A});
        tick();
        check("bd_idle", 32'(busy), 32'd0);

        // reset during WAIT_RD of req 0 (leaves ptr at 1 before reset)
        req_enc   = 4'b0010;
        req_addr  = 16'h0040;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        check("ar_busy", 32'(busy), 32'd1);
        prstn = 1'b0;
        #1;
        check("ar_out_a", {req_ready, rsp_valid, rsp_rdata, rsp_err, busy},
              32'd0);
        check("ar_out_b", {trf_valid, trf_enc, trf_addr, trf_wdata}, 32'd0);
        tick();
        prstn = 1'b1;
        seen = '0;
        for (int c = 0; c < 20; c++) begin
            tick();
            seen = seen | rsp_valid;
        end
        check("ar_norsp", 32'(seen), 32'd0);
        req_enc   = 4'b0101;
        req_valid = 2'b11;
        tick();
        check("ar_ptr0", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        wait_idle("ar_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
